// File: rtl/fetch_ctrl_pkg.sv
// fetch_ctrl shared definitions: widths, reset PC and FSM encoding.
// Timeout depth default used when FETCH_TIMEOUT_EN is defined.
package fetch_ctrl_pkg;
  localparam int          FC_WIDTH    = 32;
  localparam logic [31:0] FC_RESET_PC = 32'h0000_0000;
  localparam int          FC_TIMEOUT  = 16;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    BUSY = 2'd1,
    DROP = 2'd2
  } fetch_state_t;
endpackage

// File: rtl/fetch_pc_sel.sv
// fetch_pc_sel: next-PC priority mux for the fetch unit.
// Jump target beats branch target beats sequential PC+4.
module fetch_pc_sel #(
  parameter int WIDTH = 32
) (
  input  logic             jump,
  input  logic             branch,
  input  logic [WIDTH-1:0] pc_q,
  input  logic [WIDTH-1:0] pc_jump,
  input  logic [WIDTH-1:0] pc_branch,
  output logic [WIDTH-1:0] pc_plus4,
  output logic [WIDTH-1:0] pc_next
);

  // pick redirect target by priority, else fall through
  always_comb begin
    pc_plus4 = pc_q + WIDTH'(4);
    if (jump) begin
      pc_next = pc_jump;
    end else if (branch) begin
      pc_next = pc_branch;
    end else begin
      pc_next = pc_plus4;
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: PC owner, imem req/ack sequencer and one-entry fetch slot.
// Optional fetch timeout flag enabled by defining FETCH_TIMEOUT_EN.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int               WIDTH    = FC_WIDTH,
  parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(FC_RESET_PC)
`ifdef FETCH_TIMEOUT_EN
  ,
  parameter int               TIMEOUT  = FC_TIMEOUT
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_pc,
  input  logic             jump_decode,
  input  logic             pcsrc_decode,
  input  logic [WIDTH-1:0] pc_jump,
  input  logic [WIDTH-1:0] pc_branch,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_ack,
  input  logic [WIDTH-1:0] imem_rdata,
  output logic             fetch_valid,
  output logic [WIDTH-1:0] instr_fetch,
  output logic [WIDTH-1:0] pc_fetch,
  output logic             fetch_err
);

  fetch_state_t     state;
  fetch_state_t     state_nxt;
  logic             slot_v;
  logic             pend;
  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] instr_q;
  logic [WIDTH-1:0] pc_fetch_q;
  logic [WIDTH-1:0] pc_plus4;
  logic [WIDTH-1:0] pc_next;
  logic             redirect;
  logic             consume;
  logic             ack;
  logic             run;

  assign redirect = ~stall_pc & (jump_decode | pcsrc_decode);
  assign consume  = slot_v & ~stall_pc;
  assign ack      = imem_req & imem_ack;
  assign run      = (state != BOOT);

  fetch_pc_sel #(
    .WIDTH(WIDTH)
  ) u_pc_sel (
    .jump     (jump_decode),
    .branch   (pcsrc_decode),
    .pc_q     (pc_q),
    .pc_jump  (pc_jump),
    .pc_branch(pc_branch),
    .pc_plus4 (pc_plus4),
    .pc_next  (pc_next)
  );

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= BOOT;
    end else begin
      state <= state_nxt;
    end
  end

  // a redirect with no ack leaves a stale request to drain
  always_comb begin
    state_nxt = state;
    unique case (state)
      BOOT:    state_nxt = BUSY;
      BUSY:    if (redirect && !ack) state_nxt = DROP;
      DROP:    if (ack) state_nxt = BUSY;
      default: state_nxt = BOOT;
    endcase
  end

  // request when slot frees up; a raised request holds until ack
  always_comb begin
    imem_req = 1'b0;
    unique case (state)
      BUSY:    imem_req = pend | ~slot_v | consume;
      DROP:    imem_req = 1'b1;
      default: imem_req = 1'b0;
    endcase
  end

  // PC, slot and pending-request bookkeeping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      slot_v     <= 1'b0;
      instr_q    <= '0;
      pc_fetch_q <= '0;
      pend       <= 1'b0;
    end else begin
      pend <= imem_req & ~imem_ack;
      if (run && redirect) begin
        pc_q   <= pc_next;
        slot_v <= 1'b0;
      end else if (state == BUSY && ack) begin
        instr_q    <= imem_rdata;
        pc_fetch_q <= pc_plus4;
        slot_v     <= 1'b1;
        pc_q       <= pc_plus4;
      end else if (consume) begin
        slot_v <= 1'b0;
      end
    end
  end

  assign imem_addr   = pc_q;
  assign fetch_valid = slot_v;
  assign instr_fetch = instr_q;
  assign pc_fetch    = pc_fetch_q;

`ifdef FETCH_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] wait_cnt;
  logic          err_q;

  // count cycles of withheld ack; error sticks until reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= '0;
      err_q    <= 1'b0;
    end else if (!imem_req || imem_ack) begin
      wait_cnt <= '0;
    end else if (wait_cnt != CW'(TIMEOUT)) begin
      wait_cnt <= wait_cnt + CW'(1);
      if (wait_cnt == CW'(TIMEOUT - 1)) err_q <= 1'b1;
    end
  end

  assign fetch_err = err_q;
`else
  assign fetch_err = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed and randomized checks of fetch_ctrl
// against a transaction-level fetch model and a latency-programmable memory.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall_pc = 1'b0;
  logic        jump_decode = 1'b0;
  logic        pcsrc_decode = 1'b0;
  logic [31:0] pc_jump = '0;
  logic [31:0] pc_branch = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        fetch_valid;
  logic [31:0] instr_fetch;
  logic [31:0] pc_fetch;
  logic        fetch_err;

  always #5 clk = ~clk;

  fetch_ctrl #(
    .WIDTH(32),
    .RESET_PC(32'h0)
`ifdef FETCH_TIMEOUT_EN
    ,
    .TIMEOUT(16)
`endif
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .stall_pc    (stall_pc),
    .jump_decode (jump_decode),
    .pcsrc_decode(pcsrc_decode),
    .pc_jump     (pc_jump),
    .pc_branch   (pc_branch),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .fetch_valid (fetch_valid),
    .instr_fetch (instr_fetch),
    .pc_fetch    (pc_fetch),
    .fetch_err   (fetch_err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // reference model: expected fetch state in spec terms
  bit          m_boot;
  bit          m_stale;
  bit          m_pend;
  bit          m_sv;
  bit          m_err;
  int          m_cnt;
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [31:0] m_pcf;

  // memory: mem_wait < 0 means random 0..3 wait cycles
  int mem_wait = 0;
  bit mem_busy = 1'b0;
  int wait_left = 0;

  logic [31:0] lq_req[$];
  logic [31:0] lq_addr[$];
  logic [31:0] lq_valid[$];
  logic [31:0] lq_pcf[$];
  logic [31:0] lq_instr[$];
  logic [31:0] lq_err[$];

  function automatic logic [31:0] mw(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, ~a[15:0]};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    stall_pc = 1'b0;
    jump_decode = 1'b0;
    pcsrc_decode = 1'b0;
    imem_ack = 1'b0;
    #1;
    chk("rst_req", {31'b0, imem_req}, 32'h0);
    chk("rst_valid", {31'b0, fetch_valid}, 32'h0);
    chk("rst_pcf", pc_fetch, 32'h0);
    chk("rst_instr", instr_fetch, 32'h0);
    chk("rst_err", {31'b0, fetch_err}, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_boot = 1'b1;
    m_stale = 1'b0;
    m_pend = 1'b0;
    m_sv = 1'b0;
    m_err = 1'b0;
    m_cnt = 0;
    m_pc = 32'h0;
    m_instr = '0;
    m_pcf = '0;
    mem_busy = 1'b0;
    lq_req = {};
    lq_addr = {};
    lq_valid = {};
    lq_pcf = {};
    lq_instr = {};
    lq_err = {};
  endtask

  // one clock: drive, answer memory, compare, advance model
  task automatic step(input bit st, input bit j, input bit b,
                      input logic [31:0] pj, input logic [31:0] pb);
    bit          e_req;
    bit          acked;
    bit          redir;
    logic [31:0] tgt;
    stall_pc = st;
    jump_decode = j;
    pcsrc_decode = b;
    pc_jump = pj;
    pc_branch = pb;
    imem_ack = 1'b0;
    #1;
    e_req = m_boot ? 1'b0 : (m_stale ? 1'b1 : (m_pend || !m_sv || !st));
    if (imem_req) begin
      if (!mem_busy) begin
        mem_busy = 1'b1;
        wait_left = (mem_wait < 0) ? int'($urandom_range(0, 3)) : mem_wait;
      end
      if (wait_left == 0) begin
        imem_ack = 1'b1;
        mem_busy = 1'b0;
      end else begin
        wait_left--;
      end
    end else begin
      mem_busy = 1'b0;
    end
    imem_rdata = mw(imem_addr);
    #1;
    chk("req", {31'b0, imem_req}, {31'b0, e_req});
    if (e_req) chk("addr", imem_addr, m_pc);
    chk("valid", {31'b0, fetch_valid}, {31'b0, m_sv});
    if (m_sv) begin
      chk("instr", instr_fetch, m_instr);
      chk("pc_fetch", pc_fetch, m_pcf);
      chk("instr_vs_mem", instr_fetch, mw(pc_fetch - 32'd4));
    end
    chk("err", {31'b0, fetch_err}, {31'b0, m_err});
    lq_req.push_back({31'b0, imem_req});
    lq_addr.push_back(imem_addr);
    lq_valid.push_back({31'b0, fetch_valid});
    lq_pcf.push_back(pc_fetch);
    lq_instr.push_back(instr_fetch);
    lq_err.push_back({31'b0, fetch_err});

    acked = e_req && imem_ack;
    redir = !m_boot && !st && (j || b);
    tgt = j ? pj : pb;
`ifdef FETCH_TIMEOUT_EN
    if (!e_req || imem_ack) begin
      m_cnt = 0;
    end else begin
      m_cnt++;
      if (m_cnt >= 16) m_err = 1'b1;
    end
`endif
    if (m_boot) begin
      m_boot = 1'b0;
    end else if (m_stale) begin
      if (redir) m_pc = tgt;
      if (acked) m_stale = 1'b0;
    end else if (redir) begin
      m_pc = tgt;
      m_sv = 1'b0;
      if (!acked) m_stale = 1'b1;
    end else if (acked) begin
      m_sv = 1'b1;
      m_instr = imem_rdata;
      m_pcf = m_pc + 32'd4;
      m_pc = m_pc + 32'd4;
    end else if (!st) begin
      m_sv = 1'b0;
    end
    m_pend = e_req && !acked;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    @(posedge clk);
    #1;

    // zero-wait streaming
    mem_wait = 0;
    do_reset();
    idle(5);
    chk("a_boot_req", lq_req[0], 32'h0);
    chk("a_addr1", lq_addr[1], 32'h0);
    chk("a_addr2", lq_addr[2], 32'h4);
    chk("a_addr3", lq_addr[3], 32'h8);
    chk("a_addr4", lq_addr[4], 32'hC);
    chk("a_valid1", lq_valid[1], 32'h0);
    chk("a_valid2", lq_valid[2], 32'h1);
    chk("a_pcf2", lq_pcf[2], 32'h4);
    chk("a_pcf3", lq_pcf[3], 32'h8);
    chk("a_pcf4", lq_pcf[4], 32'hC);

    // three wait states
    mem_wait = 3;
    do_reset();
    idle(10);
    chk("b_addr1", lq_addr[1], 32'h0);
    chk("b_addr3", lq_addr[3], 32'h0);
    chk("b_addr4", lq_addr[4], 32'h0);
    chk("b_valid4", lq_valid[4], 32'h0);
    chk("b_valid5", lq_valid[5], 32'h1);
    chk("b_pcf5", lq_pcf[5], 32'h4);
    chk("b_addr8", lq_addr[8], 32'h4);
    chk("b_valid6", lq_valid[6], 32'h0);
    chk("b_pcf9", lq_pcf[9], 32'h8);

    // stall holds slot and suppresses requests
    mem_wait = 0;
    do_reset();
    idle(3);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, '0, '0);
    idle(2);
    chk("c_req3", lq_req[3], 32'h0);
    chk("c_req6", lq_req[6], 32'h0);
    chk("c_pcf3", lq_pcf[3], 32'h8);
    chk("c_pcf6", lq_pcf[6], 32'h8);
    chk("c_instr6", lq_instr[6], mw(32'h4));
    chk("c_req7", lq_req[7], 32'h1);
    chk("c_addr7", lq_addr[7], 32'h8);

    // branch with outstanding request drains through DROP
    mem_wait = 2;
    do_reset();
    idle(1);
    step(1'b0, 1'b0, 1'b1, 32'h0, 32'h100);
    idle(6);
    for (int i = 1; i <= 6; i++) chk("d_no_stale", lq_valid[i], 32'h0);
    chk("d_addr2", lq_addr[2], 32'h100);
    chk("d_req4", lq_req[4], 32'h1);
    chk("d_addr4", lq_addr[4], 32'h100);
    chk("d_valid7", lq_valid[7], 32'h1);
    chk("d_pcf7", lq_pcf[7], 32'h104);

    // jump beats branch; same-cycle ack discarded
    mem_wait = 0;
    do_reset();
    idle(1);
    step(1'b0, 1'b1, 1'b1, 32'h200, 32'h300);
    idle(2);
    chk("e_valid2", lq_valid[2], 32'h0);
    chk("e_addr2", lq_addr[2], 32'h200);
    chk("e_pcf3", lq_pcf[3], 32'h204);
    chk("e_instr3", lq_instr[3], mw(32'h200));

    // PC wrap at top of address space
    do_reset();
    idle(1);
    step(1'b0, 1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0);
    idle(2);
    chk("f_addr2", lq_addr[2], 32'hFFFF_FFFC);
    chk("f_pcf3", lq_pcf[3], 32'h0);
    chk("f_addr3", lq_addr[3], 32'h0);

`ifdef FETCH_TIMEOUT_EN
    mem_wait = 20;
    do_reset();
    idle(25);
    chk("t_err16", lq_err[16], 32'h0);
    chk("t_err17", lq_err[17], 32'h1);
    chk("t_err24", lq_err[24], 32'h1);
`endif

    // randomized traffic with a mid-run reset
    mem_wait = -1;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      step(($urandom_range(0, 3) == 0),
           ($urandom_range(0, 11) == 0),
           ($urandom_range(0, 9) == 0),
           $urandom & 32'hFFFF_FFFC,
           $urandom & 32'hFFFF_FFFC);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
Fetch sequencer for the 5-stage MIPS pipeline. It owns the program counter and drives a variable-latency instruction memory over a req/ack handshake. It merges jump and branch redirects from decode with hazard-unit stalls, and presents one buffered instruction per cycle (with PC+4) to the IF/ID register. It discards any in-flight fetch made stale by a redirect.

Parameters:
WIDTH, 32, datapath/address width.
RESET_PC, 32'h0000_0000, first fetch address after reset.
TIMEOUT, 16, cycles the memory may withhold imem_ack before an error is flagged (only used with FETCH_TIMEOUT_EN).

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous, active-high reset.
stall_pc  in  1  hazard unit: hold the fetch slot; the decode redirect is not sampled.
jump_decode  in  1  jump resolved in decode.
pcsrc_decode  in  1  taken branch resolved in decode.
pc_jump  in  WIDTH  jump target.
pc_branch  in  WIDTH  branch target.
imem_req  out  1  fetch request.
imem_addr  out  WIDTH  fetch address; word-aligned.
imem_ack  in  1  memory returns imem_rdata this cycle.
imem_rdata  in  WIDTH  instruction word.
fetch_valid  out  1  instr_fetch/pc_fetch hold a valid instruction.
instr_fetch  out  WIDTH  buffered instruction.
pc_fetch  out  WIDTH  address of buffered instruction + 4.
fetch_err  out  1  sticky fetch-timeout flag.

Behaviour:
- Reset (async, rst=1): state=BOOT, pc_q=RESET_PC, slot_v=0, instr_q=0, pc_fetch=0, imem_req=0, fetch_err=0. The first imem_req is issued the cycle after rst deasserts.
- States: BOOT, BUSY (request outstanding or issuable), DROP (stale request outstanding).
  - BOOT→BUSY unconditionally.
  - BUSY→DROP on redirect without same-cycle ack.
  - DROP→BUSY on imem_ack.
- consume = slot_v & ~stall_pc. redirect = ~stall_pc & (jump_decode | pcsrc_decode). Jump has priority over branch when both are set.
- imem_addr = pc_q; it stays stable while imem_req=1 and no ack.
- imem_req rules:
  - In BUSY: imem_req = ~slot_v | consume.
  - In DROP: imem_req = 1.
  - Once asserted, imem_req holds until ack. A rising stall cannot retract it; the returned word then lands in the empty slot.
- Ack in BUSY with no redirect:
  - instr_q<=imem_rdata, pc_fetch<=pc_q+4, slot_v<=1, pc_q<=pc_q+4.
  - With a zero-wait memory this gives one instruction per cycle; latency from ack to fetch_valid is 1 cycle.
- No ack and consume: slot_v<=0.
- stall_pc=1: slot contents, pc_q and slot_v are frozen. The only exception is an outstanding request completing into an empty slot.
- Redirect:
  - pc_q<=selected target and slot_v<=0; the buffered instruction is squashed.
  - Outstanding request with no ack this cycle: go to DROP.
  - Ack in the same cycle: discard the data and stay in BUSY at the target.
  - In DROP, the ack data is always discarded, then go to BUSY. Redirects seen while in DROP overwrite pc_q; the last one wins.
- pc_q+4 wraps modulo 2^WIDTH. No alignment checking is done.
- rst asserted mid-request: return to BOOT immediately. The memory must tolerate a dropped request.

Optional Feature:
- Macro: FETCH_TIMEOUT_EN.
- With it defined:
  - A counter clears on every ack or when imem_req=0, and increments each cycle imem_req=1 and imem_ack=0.
  - When the count reaches TIMEOUT, fetch_err sets and stays set until rst.
  - The request continues to be held.
- Without it: fetch_err is tied to 0 and no counter exists.

Decomposition:
- Shared defines: WIDTH, RESET_PC, and the state encoding (BOOT=2'd0, BUSY=2'd1, DROP=2'd2).
- One sub-module, fetch_pc_sel: the combinational next-PC priority mux (redirect target vs pc_q+4). The FSM, slot register and timeout counter stay in fetch_ctrl.

Test Plan:
- Reset release, memory acks every cycle → imem_addr 0,4,8,C on consecutive cycles; fetch_valid high from the 2nd cycle after release; pc_fetch 4,8,C.
- 3-wait-state memory → each ack comes 3 cycles after the request; imem_addr is stable throughout; fetch_valid goes high 1 cycle after each ack.
- stall_pc=1 for 4 cycles with slot_v=1 → instr_fetch and pc_fetch unchanged, imem_req=0; the next address is issued the cycle stall drops.
- pcsrc_decode=1, pc_branch=0x100, with a request outstanding (ack 2 cycles later) → enters DROP, the stale data is discarded, next imem_addr=0x100, no stale fetch_valid.
- jump_decode=1 (pc_jump=0x200) and pcsrc_decode=1 (pc_branch=0x300) with the same-cycle ack → imem_addr=0x200 next; the acked word never appears.
- FETCH_TIMEOUT_EN, TIMEOUT=16, ack withheld 20 cycles → fetch_err sets on cycle 16 and stays 1 after a later ack, until rst.
